// File: rtl/keyboard_pkg.sv
// Shared types and field definitions for the keyboard event scheduler.
package keyboard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } sched_state_t;

    localparam int PRESS_BIT = 7;
    localparam int CODE_MSB  = 6;
    localparam int CODE_LSB  = 0;

    // Left shift (0x70) and right shift (0x71) differ only in code bit 0.
    localparam logic [5:0] SHIFT_MATCH = 6'h38;

    function automatic logic is_shift_code(input logic [6:0] code);
        return (code >> 1) == {1'b0, SHIFT_MATCH};
    endfunction

endpackage

// File: rtl/keyboard_event_fifo.sv
// Small synchronous FIFO for key events; pointers carry an extra wrap bit
// so full and empty are told apart without a separate occupancy register.
module keyboard_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     w_Clk,
    input  logic                     w_Rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import keyboard_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge w_Clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer advance, wrapping modulo 2*DEPTH.
    always_ff @(posedge w_Clk or negedge w_Rst_n) begin
        if (!w_Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keyboard_event_scheduler.sv
// Replays buffered key events as single-cycle write strobes, spacing
// consecutive strobes by a hold window so software can poll each key.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | nothing being shown; pop as soon as the FIFO has an event
//   ISSUE | o_Enable high this cycle; hold counter loads next edge
//   HOLD  | counting down the hold window; pop again when it expires
module keyboard_event_scheduler #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                     w_Clk,
    input  logic                     w_Rst_n,
    input  logic [7:0]               i_Event,
    input  logic                     i_Valid,
    output logic                     o_Ready,
    input  logic                     i_ClearOvf,
    output logic [7:0]               o_KeyEvent,
    output logic                     o_Enable,
    output logic                     o_Shift,
    output logic                     o_Overflow,
    output logic [$clog2(DEPTH):0]   o_Count
);
    import keyboard_pkg::*;

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    sched_state_t  state_q;
    sched_state_t  state_d;
    logic [HW-1:0] hold_cnt;
    logic          load_hold;
    logic          fifo_pop;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          drop;

    // o_Ready comes from the pre-edge full flag, so a pop in the same
    // cycle does not rescue an event offered while full.
    assign o_Ready   = !fifo_full;
    assign fifo_push = i_Valid && !fifo_full;
    assign drop      = i_Valid && fifo_full;

    keyboard_event_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .w_Clk   (w_Clk),
        .w_Rst_n (w_Rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (i_Event),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_Count)
    );

    // Next-state decode; a pop always coincides with entry into ISSUE.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        load_hold = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                load_hold = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge w_Clk or negedge w_Rst_n) begin
        if (!w_Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold down-counter; expiry is its terminal count of zero.
    always_ff @(posedge w_Clk or negedge w_Rst_n) begin
        if (!w_Rst_n) begin
            hold_cnt <= '0;
        end else if (load_hold) begin
            hold_cnt <= HW'(HOLD_CYCLES - 1);
        end else if ((state_q == HOLD) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Issue path: capture the popped head, strobe, and follow shift keys.
    always_ff @(posedge w_Clk or negedge w_Rst_n) begin
        if (!w_Rst_n) begin
            o_KeyEvent <= 8'h00;
            o_Enable   <= 1'b0;
            o_Shift    <= 1'b0;
        end else begin
            o_Enable <= fifo_pop;
            if (fifo_pop) begin
                o_KeyEvent <= fifo_head;
                if (is_shift_code(fifo_head[CODE_MSB:CODE_LSB])) begin
                    o_Shift <= fifo_head[PRESS_BIT];
                end
            end
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set.
    always_ff @(posedge w_Clk or negedge w_Rst_n) begin
        if (!w_Rst_n) begin
            o_Overflow <= 1'b0;
        end else if (drop) begin
            o_Overflow <= 1'b1;
        end else if (i_ClearOvf) begin
            o_Overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keyboard_event_scheduler.sv
// Directed bench for keyboard_event_scheduler with DEPTH=8, HOLD_CYCLES=4.
module tb_keyboard_event_scheduler;

    localparam int DEPTH = 8;
    localparam int HOLD  = 4;

    logic       w_Clk = 1'b0;
    logic       w_Rst_n = 1'b0;
    logic [7:0] i_Event = 8'h00;
    logic       i_Valid = 1'b0;
    logic       i_ClearOvf = 1'b0;
    logic       o_Ready;
    logic [7:0] o_KeyEvent;
    logic       o_Enable;
    logic       o_Shift;
    logic       o_Overflow;
    logic [3:0] o_Count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nlog = 0;
    int base = 0;
    logic [7:0] log_ev [64];
    int         log_cyc [64];

    keyboard_event_scheduler #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .w_Clk      (w_Clk),
        .w_Rst_n    (w_Rst_n),
        .i_Event    (i_Event),
        .i_Valid    (i_Valid),
        .o_Ready    (o_Ready),
        .i_ClearOvf (i_ClearOvf),
        .o_KeyEvent (o_KeyEvent),
        .o_Enable   (o_Enable),
        .o_Shift    (o_Shift),
        .o_Overflow (o_Overflow),
        .o_Count    (o_Count)
    );

    always #5 w_Clk = ~w_Clk;

    always @(posedge w_Clk) cyc = cyc + 1;

    // Record every strobe with the cycle it appeared in.
    always @(negedge w_Clk) begin
        if (w_Rst_n && o_Enable) begin
            if (nlog < 64) begin
                log_ev[nlog]  = o_KeyEvent;
                log_cyc[nlog] = cyc;
            end
            nlog = nlog + 1;
        end
    end

    task automatic tick();
        @(posedge w_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_ready", o_Ready, 1);
        chk("rst_key", o_KeyEvent, 8'h00);
        chk("rst_enable", o_Enable, 0);
        chk("rst_shift", o_Shift, 0);
        chk("rst_ovf", o_Overflow, 0);
        chk("rst_count", o_Count, 0);
        @(negedge w_Clk);
        w_Rst_n = 1'b1;
        tick();

        // Single event: strobe in the cycle after the edge following the push
        i_Event = 8'hC1; i_Valid = 1'b1;
        tick();
        i_Valid = 1'b0;
        chk("single_cnt1", o_Count, 1);
        chk("single_en_early", o_Enable, 0);
        tick();
        chk("single_en", o_Enable, 1);
        chk("single_key", o_KeyEvent, 8'hC1);
        chk("single_cnt0", o_Count, 0);
        tick();
        chk("single_en_off", o_Enable, 0);
        chk("single_key_hold", o_KeyEvent, 8'hC1);
        repeat (10) tick();
        chk("single_nstrobe", nlog, 1);

        // Three back-to-back events: strobes spaced HOLD+1 cycles
        base = nlog;
        i_Event = 8'hA1; i_Valid = 1'b1; tick();
        chk("b2b_cnt_e1", o_Count, 1);
        i_Event = 8'hA2; tick();
        chk("b2b_cnt_e2", o_Count, 1);
        i_Event = 8'hA3; tick();
        chk("b2b_cnt_e3", o_Count, 2);
        i_Valid = 1'b0;
        repeat (15) tick();
        chk("b2b_nstrobe", nlog - base, 3);
        chk("b2b_ev0", log_ev[base], 8'hA1);
        chk("b2b_ev1", log_ev[base + 1], 8'hA2);
        chk("b2b_ev2", log_ev[base + 2], 8'hA3);
        chk("b2b_gap01", log_cyc[base + 1] - log_cyc[base], HOLD + 1);
        chk("b2b_gap12", log_cyc[base + 2] - log_cyc[base + 1], HOLD + 1);
        chk("b2b_cnt_end", o_Count, 0);

        // Shift tracking
        i_Event = 8'hF0; i_Valid = 1'b1; tick();
        i_Valid = 1'b0;
        chk("shift_pre", o_Shift, 0);
        tick();
        chk("shift_press_en", o_Enable, 1);
        chk("shift_press", o_Shift, 1);
        repeat (8) tick();
        i_Event = 8'hF2; i_Valid = 1'b1; tick();
        i_Valid = 1'b0;
        tick();
        chk("nonshift_en", o_Enable, 1);
        chk("nonshift_key", o_KeyEvent, 8'hF2);
        chk("nonshift_shift", o_Shift, 1);
        repeat (8) tick();
        i_Event = 8'h70; i_Valid = 1'b1; tick();
        i_Valid = 1'b0;
        chk("shift_rel_pre", o_Shift, 1);
        tick();
        chk("shift_rel_en", o_Enable, 1);
        chk("shift_rel", o_Shift, 0);
        repeat (8) tick();

        // Fill, drop with simultaneous clear, sticky overflow, clear
        base = nlog;
        for (int i = 1; i <= 10; i++) begin
            i_Event = 8'(i); i_Valid = 1'b1; tick();
        end
        chk("fill_cnt", o_Count, DEPTH);
        chk("fill_ready", o_Ready, 0);
        i_Event = 8'h55; i_ClearOvf = 1'b1; tick();
        i_Valid = 1'b0; i_ClearOvf = 1'b0;
        chk("drop_ovf", o_Overflow, 1);
        chk("drop_cnt", o_Count, DEPTH);
        chk("drop_ready", o_Ready, 0);
        tick();
        chk("ovf_sticky", o_Overflow, 1);
        chk("pop_cnt", o_Count, DEPTH - 1);
        chk("pop_ready", o_Ready, 1);
        i_ClearOvf = 1'b1; tick();
        i_ClearOvf = 1'b0;
        chk("ovf_clear", o_Overflow, 0);
        repeat (45) tick();
        chk("fill_nstrobe", nlog - base, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("fill_ev%0d", i), log_ev[base + i], 8'(i + 1));
        end
        chk("fill_cnt_end", o_Count, 0);

        // Push while popping at DEPTH-1 across pointer wrap
        base = nlog;
        for (int i = 0; i < 9; i++) begin
            i_Event = 8'(8'h10 + i); i_Valid = 1'b1; tick();
        end
        i_Valid = 1'b0;
        tick();
        tick();
        chk("pp_cnt_pre", o_Count, DEPTH - 1);
        chk("pp_ready_pre", o_Ready, 1);
        i_Event = 8'h19; i_Valid = 1'b1; tick();
        i_Valid = 1'b0;
        chk("pp_cnt", o_Count, DEPTH - 1);
        chk("pp_ovf", o_Overflow, 0);
        repeat (45) tick();
        chk("pp_nstrobe", nlog - base, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("pp_ev%0d", i), log_ev[base + i], 8'(8'h10 + i));
        end

        // Reset during HOLD with three events queued
        base = nlog;
        i_Event = 8'hF0; i_Valid = 1'b1; tick();
        i_Event = 8'h21; tick();
        i_Event = 8'h22; tick();
        i_Event = 8'h23; tick();
        i_Valid = 1'b0;
        chk("mid_cnt", o_Count, 3);
        chk("mid_shift", o_Shift, 1);
        w_Rst_n = 1'b0;
        #1;
        chk("mrst_cnt", o_Count, 0);
        chk("mrst_ready", o_Ready, 1);
        chk("mrst_en", o_Enable, 0);
        chk("mrst_key", o_KeyEvent, 8'h00);
        chk("mrst_shift", o_Shift, 0);
        chk("mrst_ovf", o_Overflow, 0);
        repeat (3) tick();
        @(negedge w_Clk);
        w_Rst_n = 1'b1;
        repeat (20) tick();
        chk("mrst_nstrobe", nlog - base, 1);
        chk("mrst_cnt_after", o_Count, 0);
        i_Event = 8'h33; i_Valid = 1'b1; tick();
        i_Valid = 1'b0;
        tick();
        chk("post_en", o_Enable, 1);
        chk("post_key", o_KeyEvent, 8'h33);
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
